// File: rtl/mtpsa_arb_pkg.sv
// Shared definitions for the MTPSA per-tenant egress arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mtpsa_arb_pkg;

    // Field placement and widths inside tuser and the control-plane counters.
    localparam int USER_ID_LSB = 40;
    localparam int USER_ID_W   = 8;
    localparam int PKT_CNT_W   = 32;

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mtpsa_rr_picker.sv
// Rotating-priority encoder: first requester after 'last', wrapping modulo NUM_USERS.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is used.
// Ports: req (request vector), last (index of previous winner),
//        grant (one-hot winner), idx (winner index), vld (any request present).
module mtpsa_rr_picker
    import mtpsa_arb_pkg::*;
#(
    parameter int NUM_USERS = 4,
    parameter int IDX_W     = $clog2(NUM_USERS)
) (
    input  logic [NUM_USERS-1:0] req,
    input  logic [IDX_W-1:0]     last,
    output logic [NUM_USERS-1:0] grant,
    output logic [IDX_W-1:0]     idx,
    output logic                 vld
);

    logic [IDX_W-1:0] cand;

    // Scan last+1, last+2, ... last+NUM_USERS; the previous winner is
    // considered last so it only wins again when nobody else is asking.
    always_comb begin
        grant = '0;
        idx   = '0;
        vld   = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NUM_USERS; k++) begin
            cand = IDX_W'((int'(last) + k) % NUM_USERS);
            if (!vld && req[cand]) begin
                vld         = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mtpsa_user_arbiter.sv
// Packet-granular weighted round-robin share of the egress pipeline between tenant queues.
// Latency: grant one edge after a request is seen in IDLE; zero-cycle data path while in PKT.
// Backpressure: m_axis_tready passes straight to the granted user's tready; others held at 0.
// Ports: s_axis_* (NUM_USERS packed slave streams), m_axis_* (single master stream with
//        user index stamped in tuser[47:40]), cfg_weight/cfg_enable (per-user control),
//        pkt_count (per-user forwarded packets, wrapping), cur_grant (one-hot debug).
module mtpsa_user_arbiter
    import mtpsa_arb_pkg::*;
#(
    parameter int NUM_USERS    = 4,
    parameter int DATA_WIDTH   = 256,
    parameter int TUSER_WIDTH  = 128,
    parameter int WEIGHT_WIDTH = 4
) (
    input  logic                                 axis_aclk,
    input  logic                                 axis_rst,
    input  logic [NUM_USERS*DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [NUM_USERS*DATA_WIDTH/8-1:0]    s_axis_tkeep,
    input  logic [NUM_USERS*TUSER_WIDTH-1:0]     s_axis_tuser,
    input  logic [NUM_USERS-1:0]                 s_axis_tvalid,
    input  logic [NUM_USERS-1:0]                 s_axis_tlast,
    output logic [NUM_USERS-1:0]                 s_axis_tready,
    output logic [DATA_WIDTH-1:0]                m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]              m_axis_tkeep,
    output logic [TUSER_WIDTH-1:0]               m_axis_tuser,
    output logic                                 m_axis_tvalid,
    output logic                                 m_axis_tlast,
    input  logic                                 m_axis_tready,
    input  logic [NUM_USERS*WEIGHT_WIDTH-1:0]    cfg_weight,
    input  logic [NUM_USERS-1:0]                 cfg_enable,
    output logic [NUM_USERS*PKT_CNT_W-1:0]       pkt_count,
    output logic [NUM_USERS-1:0]                 cur_grant
);

    localparam int IDX_W  = $clog2(NUM_USERS);
    localparam int KEEP_W = DATA_WIDTH / 8;

    arb_state_t                           state_q, state_n;
    logic [IDX_W-1:0]                     last_q, last_n;
    logic [WEIGHT_WIDTH-1:0]              burst_q, burst_n;
    logic [NUM_USERS-1:0]                 grant_q, grant_n;
    logic [NUM_USERS-1:0][PKT_CNT_W-1:0]  pkt_cnt_q;

    logic [NUM_USERS-1:0]    req;
    logic [NUM_USERS-1:0]    pick_grant;
    logic [IDX_W-1:0]        pick_idx;
    logic                    pick_vld;
    logic [WEIGHT_WIDTH-1:0] cur_w, eff_w;
    logic                    keep_burst;
    logic                    in_pkt;
    logic                    g_vld, g_last;
    logic                    pkt_done;

    assign req = s_axis_tvalid & cfg_enable;

    mtpsa_rr_picker #(
        .NUM_USERS (NUM_USERS),
        .IDX_W     (IDX_W)
    ) u_picker (
        .req   (req),
        .last  (last_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .vld   (pick_vld)
    );

    // Weight of the current burst owner, with 0 meaning a single packet.
    assign cur_w = cfg_weight[int'(last_q)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    assign eff_w = (cur_w == '0) ? WEIGHT_WIDTH'(1) : cur_w;

    // burst_q == 0 only out of reset: no burst is in progress yet, so the
    // reset value of last_q merely seeds the rotation and user 0 wins first.
    assign keep_burst = (burst_q != '0) && req[last_q] && (burst_q < eff_w);

    // last_q always holds the granted index while in PKT.
    assign in_pkt   = (state_q == PKT);
    assign g_vld    = s_axis_tvalid[last_q];
    assign g_last   = s_axis_tlast[last_q];
    assign pkt_done = in_pkt && g_vld && m_axis_tready && g_last;

    // State register.
    always_ff @(posedge axis_aclk or posedge axis_rst) begin
        if (axis_rst) begin
            state_q <= IDLE;
            last_q  <= IDX_W'(NUM_USERS - 1);
            burst_q <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_n;
            last_q  <= last_n;
            burst_q <= burst_n;
            grant_q <= grant_n;
        end
    end

    // Next-state and grant decision.
    always_comb begin
        state_n = state_q;
        last_n  = last_q;
        burst_n = burst_q;
        grant_n = grant_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_n = PKT;
                    if (keep_burst) begin
                        burst_n = burst_q + 1'b1;
                        grant_n = NUM_USERS'(1) << last_q;
                    end else begin
                        last_n  = pick_idx;
                        burst_n = WEIGHT_WIDTH'(1);
                        grant_n = pick_grant;
                    end
                end
            end
            PKT: begin
                if (pkt_done) begin
                    state_n = IDLE;
                    grant_n = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs: a plain mux of the granted slave, gated by the PKT state so
    // that an asynchronous reset silences the stream immediately.
    always_comb begin
        m_axis_tdata  = s_axis_tdata[int'(last_q)*DATA_WIDTH +: DATA_WIDTH];
        m_axis_tkeep  = s_axis_tkeep[int'(last_q)*KEEP_W +: KEEP_W];
        m_axis_tuser  = s_axis_tuser[int'(last_q)*TUSER_WIDTH +: TUSER_WIDTH];
        m_axis_tuser[USER_ID_LSB +: USER_ID_W] = USER_ID_W'(last_q);
        m_axis_tvalid = in_pkt && g_vld;
        m_axis_tlast  = in_pkt && g_last;
        s_axis_tready = in_pkt ? (grant_q & {NUM_USERS{m_axis_tready}}) : '0;
        cur_grant     = grant_q;
    end

    // Forwarded-packet counters, free-running and wrapping.
    always_ff @(posedge axis_aclk or posedge axis_rst) begin
        if (axis_rst) begin
            pkt_cnt_q <= '0;
        end else if (pkt_done) begin
            pkt_cnt_q[last_q] <= pkt_cnt_q[last_q] + 1'b1;
        end
    end

    assign pkt_count = pkt_cnt_q;

endmodule

// File: tb/tb_mtpsa_user_arbiter.sv
// Self-checking bench for mtpsa_user_arbiter: table of arbitration scenarios plus
// hand-written corner sequences; every forwarded beat is checked against a scoreboard.
// Runs entirely from one initial block; all waits are cycle-bounded.
module tb_mtpsa_user_arbiter;

    localparam int N  = 4;
    localparam int DW = 256;
    localparam int TW = 128;
    localparam int WW = 4;
    localparam int KW = DW / 8;

    logic              axis_aclk = 1'b0;
    logic              axis_rst;
    logic [N*DW-1:0]   s_axis_tdata;
    logic [N*KW-1:0]   s_axis_tkeep;
    logic [N*TW-1:0]   s_axis_tuser;
    logic [N-1:0]      s_axis_tvalid;
    logic [N-1:0]      s_axis_tlast;
    logic [N-1:0]      s_axis_tready;
    logic [DW-1:0]     m_axis_tdata;
    logic [KW-1:0]     m_axis_tkeep;
    logic [TW-1:0]     m_axis_tuser;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic              m_axis_tready;
    logic [N*WW-1:0]   cfg_weight;
    logic [N-1:0]      cfg_enable;
    logic [N*32-1:0]   pkt_count;
    logic [N-1:0]      cur_grant;

    mtpsa_user_arbiter #(
        .NUM_USERS    (N),
        .DATA_WIDTH   (DW),
        .TUSER_WIDTH  (TW),
        .WEIGHT_WIDTH (WW)
    ) dut (
        .axis_aclk     (axis_aclk),
        .axis_rst      (axis_rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .cfg_weight    (cfg_weight),
        .cfg_enable    (cfg_enable),
        .pkt_count     (pkt_count),
        .cur_grant     (cur_grant)
    );

    always #5 axis_aclk = ~axis_aclk;

    typedef struct packed {
        logic [DW-1:0] dat;
        logic [KW-1:0] keep;
        logic [TW-1:0] user;
        logic          last;
    } beat_t;

    typedef struct {
        logic [N-1:0]    on;
        logic [N-1:0]    en;
        logic [N*WW-1:0] w;
        int              plen;
        int              npkt;
        logic [31:0]     seq;   // expected winner per packet, one nibble each, first in [3:0]
    } vec_t;

    beat_t        sb_q[$];
    int           grant_log[$];
    int           beat[N];
    int           pno[N];
    int           plen[N];
    logic [N-1:0] src_on;
    logic [N-1:0] allowed;
    int           rdy_mode;
    int           cyc;
    int           done_pkts;
    int           nbeats;
    int           last_end_cyc;
    bit           chk_gap;
    bit           auto_off;
    int           stop_at;
    int           checks;
    int           errors;

    task automatic check(input string name, input logic ok,
                         input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic beat_t mk_beat(input int u, input int p, input int b,
                                      input int len, input logic stamped);
        beat_t       r;
        logic [31:0] w;
        w             = {8'(u) ^ 8'h5A, 16'(p), 8'(b)};
        r.dat         = {(DW/32){w}};
        r.last        = (b == len - 1);
        r.keep        = r.last ? {{(KW/2){1'b0}}, {(KW/2){1'b1}}} : {KW{1'b1}};
        r.user        = '0;
        r.user[15:0]  = 16'(len * 32);
        r.user[23:16] = 8'(1 << u);
        r.user[31:24] = 8'h01;
        r.user[39:32] = 8'(p);
        r.user[47:40] = stamped ? 8'(u) : 8'hEE;
        return r;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            beat_t b;
            b = mk_beat(i, pno[i], beat[i], plen[i], 1'b0);
            s_axis_tvalid[i]          = src_on[i];
            s_axis_tdata[i*DW +: DW]  = b.dat;
            s_axis_tkeep[i*KW +: KW]  = b.keep;
            s_axis_tuser[i*TW +: TW]  = b.user;
            s_axis_tlast[i]           = b.last;
        end
        m_axis_tready = (rdy_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
    endtask

    // One clock: sample at the falling edge, update sources just after the rising edge.
    task automatic tick();
        logic [N-1:0] hs;
        int           hu;
        int           nhs;
        beat_t        exp_b;
        @(negedge axis_aclk);
        cyc++;
        hs  = s_axis_tvalid & s_axis_tready;
        nhs = 0;
        hu  = 0;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                nhs++;
                hu = i;
            end
        end
        check("tready_mask",
              ((s_axis_tready & ~allowed) === '0) &&
              (m_axis_tready || (s_axis_tready === '0)) &&
              ($countones(s_axis_tready) <= 1),
              512'(s_axis_tready), 512'(allowed));
        if (m_axis_tvalid === 1'b1 && m_axis_tready) begin
            check("handoff_one_src", nhs == 1, 512'(nhs), 512'(1));
            if (nhs == 1) begin
                sb_q.push_back(mk_beat(hu, pno[hu], beat[hu], plen[hu], 1'b1));
                exp_b = sb_q.pop_front();
                check("beat_data",
                      {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} === exp_b,
                      512'({m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast}),
                      512'(exp_b));
                nbeats++;
                if (beat[hu] == 0) begin
                    grant_log.push_back(hu);
                    if (chk_gap && last_end_cyc >= 0)
                        check("one_bubble", (cyc - last_end_cyc) == 2,
                              512'(cyc - last_end_cyc), 512'(2));
                end
                if (exp_b.last) begin
                    done_pkts++;
                    last_end_cyc = cyc;
                end
            end
        end else begin
            check("no_stray_accept", nhs == 0, 512'(hs), 512'(0));
        end
        @(posedge axis_aclk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                if (beat[i] == plen[i] - 1) begin
                    beat[i] = 0;
                    pno[i]++;
                end else begin
                    beat[i]++;
                end
            end
        end
        if (auto_off && done_pkts >= stop_at) src_on = '0;
        drive();
    endtask

    task automatic run_until(input int target, input int budget);
        int start;
        start = cyc;
        while (done_pkts < target && (cyc - start) < budget) tick();
        check("pkt_timeout", done_pkts >= target, 512'(done_pkts), 512'(target));
    endtask

    task automatic clear_sources();
        for (int i = 0; i < N; i++) begin
            beat[i] = 0;
            pno[i]  = 0;
            plen[i] = 1;
        end
        src_on       = '0;
        sb_q.delete();
        grant_log.delete();
        done_pkts    = 0;
        nbeats       = 0;
        last_end_cyc = -1;
    endtask

    task automatic do_reset();
        axis_rst = 1'b1;
        clear_sources();
        drive();
        repeat (2) @(posedge axis_aclk);
        @(negedge axis_aclk);
        check("reset_state",
              {m_axis_tvalid, m_axis_tlast, s_axis_tready, cur_grant, pkt_count} === '0,
              512'({m_axis_tvalid, m_axis_tlast, s_axis_tready, cur_grant, pkt_count}),
              512'(0));
        axis_rst = 1'b0;
        @(posedge axis_aclk);
        #1;
    endtask

    vec_t         vecs[5];
    logic [31:0]  act_seq;
    int           exp_cnt;
    logic         ever_g1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        rdy_mode = 0;
        allowed  = '1;
        chk_gap  = 1'b0;
        auto_off = 1'b1;
        stop_at  = 0;
        cfg_weight = {N{4'h1}};
        cfg_enable = '1;
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tuser  = '0;
        s_axis_tlast  = '0;
        m_axis_tready = 1'b0;
        axis_rst      = 1'b1;

        vecs[0] = '{on: 4'hF, en: 4'hF, w: 16'h1111, plen: 2, npkt: 5, seq: 32'h0000_3210};
        vecs[1] = '{on: 4'hF, en: 4'hF, w: 16'h1131, plen: 1, npkt: 8, seq: 32'h1032_1110};
        vecs[2] = '{on: 4'hA, en: 4'hF, w: 16'h0000, plen: 3, npkt: 4, seq: 32'h0000_3131};
        vecs[3] = '{on: 4'hF, en: 4'hB, w: 16'h1111, plen: 1, npkt: 6, seq: 32'h0031_0310};
        vecs[4] = '{on: 4'h9, en: 4'hF, w: 16'h2000, plen: 2, npkt: 6, seq: 32'h0033_0330};

        // Table: backlogged users, full-rate egress, packet winner order and counters.
        for (int v = 0; v < 5; v++) begin
            rdy_mode = 0;
            do_reset();
            cfg_weight = vecs[v].w;
            cfg_enable = vecs[v].en;
            for (int i = 0; i < N; i++) plen[i] = vecs[v].plen;
            src_on   = vecs[v].on;
            allowed  = vecs[v].on & vecs[v].en;
            chk_gap  = 1'b1;
            auto_off = 1'b1;
            stop_at  = vecs[v].npkt;
            drive();
            run_until(vecs[v].npkt, 400);
            act_seq = '0;
            for (int k = 0; k < grant_log.size() && k < 8; k++)
                act_seq[4*k +: 4] = 4'(grant_log[k]);
            check($sformatf("grant_seq[%0d]", v), act_seq === vecs[v].seq,
                  512'(act_seq), 512'(vecs[v].seq));
            for (int u = 0; u < N; u++) begin
                exp_cnt = 0;
                for (int k = 0; k < vecs[v].npkt; k++)
                    if (int'(vecs[v].seq[4*k +: 4]) == u) exp_cnt++;
                check($sformatf("pkt_count[%0d][%0d]", v, u),
                      pkt_count[u*32 +: 32] === 32'(exp_cnt),
                      512'(pkt_count[u*32 +: 32]), 512'(exp_cnt));
            end
        end
        chk_gap = 1'b0;

        // 5-beat packet from user 2 with egress ready toggling every cycle.
        do_reset();
        cfg_weight = 16'h1111;
        cfg_enable = '1;
        rdy_mode   = 1;
        plen[2]    = 5;
        src_on     = 4'b0100;
        allowed    = 4'b0100;
        auto_off   = 1'b1;
        stop_at    = 1;
        drive();
        @(negedge axis_aclk);
        check("grant_lat_idle", {m_axis_tvalid, cur_grant} === 5'b0_0000,
              512'({m_axis_tvalid, cur_grant}), 512'(5'b0_0000));
        @(posedge axis_aclk);
        #1;
        check("grant_lat_next", {m_axis_tvalid, cur_grant} === 5'b1_0100,
              512'({m_axis_tvalid, cur_grant}), 512'(5'b1_0100));
        run_until(1, 60);
        check("toggle_beats", nbeats == 5, 512'(nbeats), 512'(5));
        check("toggle_count", pkt_count[2*32 +: 32] === 32'd1,
              512'(pkt_count[2*32 +: 32]), 512'(1));

        // User 1 disabled mid-packet: packet completes, no later grant.
        rdy_mode = 0;
        do_reset();
        cfg_enable = '1;
        plen[1]    = 4;
        src_on     = 4'b0010;
        allowed    = 4'b0010;
        auto_off   = 1'b0;
        drive();
        tick();
        tick();
        cfg_enable = 4'b1101;
        run_until(1, 40);
        ever_g1 = 1'b0;
        repeat (12) begin
            tick();
            if (cur_grant[1] !== 1'b0) ever_g1 = 1'b1;
        end
        check("disabled_no_regrant", {ever_g1, 8'(done_pkts)} === {1'b0, 8'd1},
              512'({ever_g1, 8'(done_pkts)}), 512'({1'b0, 8'd1}));
        check("disabled_count", pkt_count[1*32 +: 32] === 32'd1,
              512'(pkt_count[1*32 +: 32]), 512'(1));

        // Asynchronous reset in the middle of an 8-beat packet from user 0.
        cfg_enable = '1;
        src_on     = 4'b0001;
        allowed    = 4'b0001;
        plen[0]    = 8;
        drive();
        for (int t = 0; t < 20 && beat[0] != 3; t++) tick();
        check("mid_pkt_vld", m_axis_tvalid === 1'b1, 512'(m_axis_tvalid), 512'(1));
        #2;
        axis_rst = 1'b1;
        #1;
        check("async_rst_out",
              {m_axis_tvalid, m_axis_tlast, s_axis_tready, cur_grant} === '0,
              512'({m_axis_tvalid, m_axis_tlast, s_axis_tready, cur_grant}), 512'(0));
        check("async_rst_cnt", pkt_count === '0, 512'(pkt_count), 512'(0));
        @(posedge axis_aclk);
        @(negedge axis_aclk);
        axis_rst = 1'b0;
        clear_sources();
        plen[0]  = 2;
        plen[3]  = 2;
        src_on   = 4'b1001;
        allowed  = 4'b1001;
        auto_off = 1'b1;
        stop_at  = 1;
        drive();
        @(posedge axis_aclk);
        #1;
        run_until(1, 40);
        check("first_after_rst", grant_log.size() > 0 && grant_log[0] == 0,
              512'(grant_log.size() > 0 ? grant_log[0] : -1), 512'(0));
        check("cnt_after_rst", pkt_count === {32'd0, 32'd0, 32'd0, 32'd1},
              512'(pkt_count), 512'({32'd0, 32'd0, 32'd0, 32'd1}));

        // Counter wrap: preload user 0 to all-ones, send one packet.
        force dut.pkt_cnt_q = {96'h0, 32'hFFFF_FFFF};
        @(posedge axis_aclk);
        @(negedge axis_aclk);
        release dut.pkt_cnt_q;
        @(posedge axis_aclk);
        #1;
        check("cnt_preload", pkt_count[31:0] === 32'hFFFF_FFFF,
              512'(pkt_count[31:0]), 512'(32'hFFFF_FFFF));
        done_pkts = 0;
        src_on    = 4'b0001;
        allowed   = 4'b0001;
        stop_at   = 1;
        drive();
        run_until(1, 40);
        check("cnt_wrap", pkt_count[31:0] === 32'd0, 512'(pkt_count[31:0]), 512'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
